fib_stream_buffer: RTL and testbench
====================================

# fib_stream_buffer

Downstream consumer of the Fibonacci generator's term stream. Captures each generated term into a small synchronous FIFO, checks the terms against the Fibonacci recurrence, and counts terms. It then presents the terms to the next stage over a valid/ready handshake, so a stalling consumer does not need to throttle the free-running generator. End of sequence is taken from the generator's done indication and forwarded as a tagged last word, followed by a completion pulse.

## Interface
- DATA_W, 32: term width; must match generator output width.
- DEPTH, 8: FIFO entries; power of two, ≥2.
- CNT_W, 16: width of term counter and error index.

- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- clr  in  1  synchronous clear of sticky flags and counters; FIFO and FSM also return to reset state.
- in_valid  in  1  term present on in_data this cycle (generator enable-qualified).
- in_data  in  DATA_W  Fibonacci term from generator.
- in_last  in  1  this term is final (generator done).
- out_valid  out  1  FIFO non-empty.
- out_data  out  DATA_W  head-of-FIFO term.
- out_last  out  1  head term carries last tag.
- out_ready  in  1  consumer accepts head when out_valid & out_ready.
- term_count  out  CNT_W  terms observed in RUN, saturating.
- seq_err  out  1  sticky recurrence mismatch.
- err_index  out  CNT_W  index (0-based) of first mismatching term.
- overflow  out  1  sticky: term arrived with FIFO full and no pop.
- seq_done  out  1  one-cycle completion pulse.

## Operation
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE: first in_valid is term 0; it is processed as a RUN term and the FSM moves to RUN. If that first term also has in_last, the FSM goes directly to DRAIN.
- RUN: every in_valid term is counted, checked, and pushed. A term with in_last moves the FSM to DRAIN.
- DRAIN: in_valid is ignored (not counted, not pushed, no flags). When the FIFO becomes empty, the FSM moves to DONE.
- DONE: seq_done=1 for exactly one cycle, then IDLE.
- Push rule:
  - A term is accepted if the FIFO is not full, or if a pop occurs in the same cycle.
  - Otherwise the term is dropped, overflow is set, and the term is still counted and checked.
- The FIFO stores {last, data}. Simultaneous push and pop when empty: the pushed word is written and the pop is ignored, because out_valid was 0.
- Checker:
  - Expected values: term0=0, term1=1, termk=(termk-1 + termk-2) mod 2^DATA_W.
  - Carry is discarded, so wrap-around is legal.
  - The first mismatch sets seq_err and latches err_index. Later mismatches do not update err_index.
  - Predecessor registers are loaded with the received values, so the check continues relative to the actual stream.
- term_count saturates at 2^CNT_W-1.
- Reset values (rst_n low, or clr): FIFO empty, out_valid=0, out_data=0, out_last=0, term_count=0, seq_err=0, err_index=0, overflow=0, seq_done=0, FSM=IDLE.
- Reset mid-sequence discards all buffered terms immediately (asynchronously).

## Timing
- Push at edge N: out_valid=1 after edge N when the FIFO was empty (1-cycle latency). out_data is registered FIFO storage and is valid in the same cycle as out_valid.
- Pop at edge N: the next head, or out_valid=0, is visible after edge N.
- seq_err, err_index, term_count and overflow update on the edge that samples the term.
- seq_done asserts the cycle after the edge that pops the last entry.
- Throughput: one push and one pop per cycle, sustained.
- clr has priority over a concurrent in_valid.

## Configuration
- FIB_STREAM_CHECK_EN defined: recurrence checker is present; seq_err and err_index function as specified.
- FIB_STREAM_CHECK_EN undefined: checker and predecessor registers are removed; seq_err and err_index are tied to 0. All other behaviour is unchanged.

## Structure
- Shared package fib_pkg: FSM state enum (IDLE/RUN/DRAIN/DONE), FIFO entry struct {last, data}, constant FIB_SEED0=0 and FIB_SEED1=1.
- One sub-module, fib_sync_fifo: parameterised DEPTH×(DATA_W+1), with full/empty, pointer wrap via an extra MSB, and simultaneous push/pop.
- FSM, checker and counters live in the top module.

## Test plan
- Generator max_value=50, out_ready=1:
  - out stream is 0,1,1,2,3,5,8,13,21,34, with out_last on 34.
  - term_count=10, seq_err=0, overflow=0.
  - One seq_done pulse after the last pop.
- out_ready=0, same 10 terms, DEPTH=8:
  - 8 terms are stored (0..13) and 2 are dropped.
  - overflow=1, term_count=10, FIFO stays full.
  - Raising out_ready drains 0..13, then DRAIN does not end until empty. Note: last was dropped, so inject clr to recover; expect all outputs at their reset values.
- Inject 0,1,1,2,4,6:
  - seq_err=1 with err_index=4 after the 5th term.
  - err_index is unchanged after term 6, which matches against the received values 2+4.
- DATA_W=8, feed the true sequence through 233, then 121 (377 mod 256): seq_err stays 0.
- Push 3 terms with out_ready=0, then pulse rst_n low mid-cycle: out_valid=0, term_count=0, FSM=IDLE immediately. The next stream restarts at index 0.
- FIB_STREAM_CHECK_EN undefined with the error stream 0,1,1,2,4: seq_err=0, err_index=0, and all 5 terms are delivered.

Source files
------------

// File: rtl/fib_pkg.sv
// fib_pkg: shared state encoding, FIFO entry layout and recurrence seeds for
// the Fibonacci stream buffer.
package fib_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } fib_state_e;

    // Entry layout at the generator's native width; the top module builds the
    // same {last, data} layout at its own DATA_W.
    localparam int unsigned FIB_DATA_W = 32;

    typedef struct packed {
        logic                  last;
        logic [FIB_DATA_W-1:0] data;
    } fib_entry_t;

    localparam int unsigned FIB_SEED0 = 0;
    localparam int unsigned FIB_SEED1 = 1;

endpackage

// File: rtl/fib_sync_fifo.sv
// fib_sync_fifo: DEPTH x WIDTH synchronous FIFO. Pointers carry an extra MSB
// so full and empty are distinguished without a separate counter. A push is
// accepted when not full or when a pop happens in the same cycle; a pop on an
// empty FIFO is ignored.
module fib_sync_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 33
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clr,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign count   = wr_ptr - rd_ptr;
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // Head word is read straight from storage; forced to zero while empty so
    // the output bus shows its reset value until something is written.
    assign rdata = empty ? '0 : mem[rd_ptr[AW-1:0]];

    // Pointer update; clr returns the FIFO to empty
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    // Storage write; contents need no reset because empty masks the read port
    always_ff @(posedge clk) begin
        if (do_push && !clr) mem[wr_ptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/fib_stream_buffer.sv
// fib_stream_buffer: captures Fibonacci generator terms into a FIFO, counts
// them, checks the recurrence and forwards them over valid/ready with a last
// tag, followed by a one-cycle seq_done pulse once the FIFO drains.
// Build option: define FIB_STREAM_CHECK_EN to include the recurrence checker;
// without it seq_err and err_index are tied to zero.
module fib_stream_buffer
    import fib_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    input  logic              out_ready,
    output logic [CNT_W-1:0]  term_count,
    output logic              seq_err,
    output logic [CNT_W-1:0]  err_index,
    output logic              overflow,
    output logic              seq_done
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] CNT_ONE_ENTRY = 1;

    typedef struct packed {
        logic              last;
        logic [DATA_W-1:0] data;
    } entry_t;

    fib_state_e  state;
    logic        take;
    logic        pop_fire;
    logic        fifo_full;
    logic        fifo_empty;
    logic [AW:0] fifo_count;
    logic [DATA_W:0] wr_word;
    logic [DATA_W:0] rd_word;
    entry_t      wr_entry;
    entry_t      head;

    // A term is processed only while collecting a sequence; clr wins
    assign take      = in_valid && !clr && (state == IDLE || state == RUN);
    assign out_valid = !fifo_empty;
    assign pop_fire  = out_valid && out_ready;
    assign wr_entry  = '{last: in_last, data: in_data};
    assign wr_word   = wr_entry;
    assign head      = rd_word;
    assign out_data  = head.data;
    assign out_last  = head.last;
    assign seq_done  = (state == DONE);

    fib_sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (DATA_W + 1)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .push  (take),
        .pop   (out_ready),
        .wdata (wr_word),
        .rdata (rd_word),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Sequence FSM; DRAIN ends on the edge that pops the final entry so that
    // seq_done is high in the very next cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else if (clr) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE, RUN: begin
                    if (take) state <= in_last ? DRAIN : RUN;
                end
                DRAIN: begin
                    if (fifo_empty || (pop_fire && fifo_count == CNT_ONE_ENTRY))
                        state <= DONE;
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Saturating term counter and sticky overflow for terms that find no room
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            term_count <= '0;
            overflow   <= 1'b0;
        end else if (clr) begin
            term_count <= '0;
            overflow   <= 1'b0;
        end else if (take) begin
            if (term_count != '1) term_count <= term_count + CNT_W'(1);
            if (fifo_full && !pop_fire) overflow <= 1'b1;
        end
    end

`ifdef FIB_STREAM_CHECK_EN
    logic [DATA_W-1:0] prev1;
    logic [DATA_W-1:0] prev2;
    logic [DATA_W-1:0] expected;
    logic              at_one;

    // Expected value: seeds for the first two terms of a sequence, then the
    // wrapping sum of the two previously received terms
    always_comb begin
        expected = prev1 + prev2;
        if (state == IDLE) expected = DATA_W'(FIB_SEED0);
        else if (at_one)   expected = DATA_W'(FIB_SEED1);
    end

    // Recurrence check; predecessors track the received stream, first error latched
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev1     <= '0;
            prev2     <= '0;
            at_one    <= 1'b0;
            seq_err   <= 1'b0;
            err_index <= '0;
        end else if (clr) begin
            prev1     <= '0;
            prev2     <= '0;
            at_one    <= 1'b0;
            seq_err   <= 1'b0;
            err_index <= '0;
        end else if (take) begin
            if (in_data != expected && !seq_err) begin
                seq_err   <= 1'b1;
                err_index <= term_count;
            end
            prev2  <= prev1;
            prev1  <= in_data;
            at_one <= (state == IDLE);
        end
    end
`else
    assign seq_err   = 1'b0;
    assign err_index = '0;
`endif

endmodule

// File: tb/tb_fib_stream_buffer.sv
// tb_fib_stream_buffer: randomized and directed stimulus against a queue-based
// reference model of the stream buffer; an 8-bit instance covers wrap-around.
module tb_fib_stream_buffer;

`ifdef FIB_STREAM_CHECK_EN
    localparam bit CHECK_EN = 1'b1;
`else
    localparam bit CHECK_EN = 1'b0;
`endif
    localparam int DEPTH   = 8;
    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_DRAIN = 2;
    localparam int M_DONE  = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clr = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_data = '0;
    logic        in_last = 1'b0;
    logic        out_ready = 1'b0;
    logic        out_valid;
    logic [31:0] out_data;
    logic        out_last;
    logic [15:0] term_count;
    logic        seq_err;
    logic [15:0] err_index;
    logic        overflow;
    logic        seq_done;

    logic        v8 = 1'b0;
    logic [7:0]  d8 = '0;
    logic        l8 = 1'b0;
    logic        r8 = 1'b1;
    logic        out_valid8;
    logic [7:0]  out_data8;
    logic        out_last8;
    logic [15:0] term_count8;
    logic        seq_err8;
    logic [15:0] err_index8;
    logic        overflow8;
    logic        seq_done8;

    logic [68:0] obs_vec;
    int checks = 0;
    int failures = 0;

    // Reference model state
    logic [32:0] m_q[$];
    int          m_mode;
    int          m_cnt;
    bit          m_err;
    int          m_eidx;
    bit          m_ovf;
    logic [31:0] m_p1;
    logic [31:0] m_p2;
    int          m_k;

    fib_stream_buffer #(.DATA_W(32), .DEPTH(DEPTH), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .clr(clr),
        .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
        .out_ready(out_ready), .term_count(term_count), .seq_err(seq_err),
        .err_index(err_index), .overflow(overflow), .seq_done(seq_done)
    );

    fib_stream_buffer #(.DATA_W(8), .DEPTH(DEPTH), .CNT_W(16)) dut8 (
        .clk(clk), .rst_n(rst_n), .clr(clr),
        .in_valid(v8), .in_data(d8), .in_last(l8),
        .out_valid(out_valid8), .out_data(out_data8), .out_last(out_last8),
        .out_ready(r8), .term_count(term_count8), .seq_err(seq_err8),
        .err_index(err_index8), .overflow(overflow8), .seq_done(seq_done8)
    );

    assign obs_vec = {out_valid, out_data, out_last, term_count, seq_err,
                      err_index, overflow, seq_done};

    always #5 clk = ~clk;

    function automatic void model_reset();
        m_q.delete();
        m_mode = M_IDLE;
        m_cnt  = 0;
        m_err  = 1'b0;
        m_eidx = 0;
        m_ovf  = 1'b0;
        m_p1   = '0;
        m_p2   = '0;
        m_k    = 0;
    endfunction

    // One clock of the buffer's behaviour, from the inputs present before the edge
    function automatic void model_step(input bit v, input logic [31:0] d,
                                       input bit l, input bit rdy, input bit c);
        bit pop;
        bit full;
        logic [31:0] expv;
        if (c) begin
            model_reset();
            return;
        end
        full = (m_q.size() == DEPTH);
        pop  = (m_q.size() > 0) && rdy;
        if (pop) void'(m_q.pop_front());
        if (v && (m_mode == M_IDLE || m_mode == M_RUN)) begin
            if (m_mode == M_IDLE) m_k = 0;
            expv = (m_k == 0) ? 32'd0 : (m_k == 1) ? 32'd1 : m_p1 + m_p2;
            if (CHECK_EN && d !== expv && !m_err) begin
                m_err  = 1'b1;
                m_eidx = m_cnt;
            end
            m_p2 = m_p1;
            m_p1 = d;
            m_k++;
            if (m_cnt < 65535) m_cnt++;
            if (!full || pop) m_q.push_back({l, d});
            else m_ovf = 1'b1;
            m_mode = l ? M_DRAIN : M_RUN;
        end else if (m_mode == M_DRAIN) begin
            if (m_q.size() == 0) m_mode = M_DONE;
        end else if (m_mode == M_DONE) begin
            m_mode = M_IDLE;
        end
    endfunction

    function automatic logic [68:0] model_vec();
        logic [32:0] h;
        h = (m_q.size() > 0) ? m_q[0] : 33'd0;
        return {m_q.size() > 0, h[31:0], h[32], 16'(m_cnt), m_err,
                16'(m_eidx), m_ovf, m_mode == M_DONE};
    endfunction

    task automatic tick();
        model_step(in_valid, in_data, in_last, out_ready, clr);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        @(posedge clk);
        #1;
        checks++;
        if (obs_vec !== 69'd0) begin
            failures++;
            $display("FAIL reset_outputs got=%h exp=%h", obs_vec, 69'd0);
        end
        checks++;
        if ({out_valid8, out_data8, term_count8, seq_err8, overflow8} !== 27'd0) begin
            failures++;
            $display("FAIL reset_outputs8 got=%h exp=0",
                     {out_valid8, out_data8, term_count8, seq_err8, overflow8});
        end
        rst_n = 1'b1;
        model_reset();
        tick();
        checks++;
        if (obs_vec !== model_vec()) begin
            failures++;
            $display("FAIL reset_release got=%h exp=%h", obs_vec, model_vec());
        end
    endtask

    task automatic test_basic();
        logic [31:0] fib[10] = '{0, 1, 1, 2, 3, 5, 8, 13, 21, 34};
        logic [32:0] got[$];
        int dones = 0;
        clr = 1'b1; tick(); clr = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 30; i++) begin
            in_valid = (i < 10);
            in_data  = (i < 10) ? fib[i] : 32'd0;
            in_last  = (i == 9);
            if (out_valid && out_ready) got.push_back({out_last, out_data});
            tick();
            if (seq_done) dones++;
            checks++;
            if (obs_vec !== model_vec()) begin
                failures++;
                $display("FAIL basic_cycle%0d got=%h exp=%h", i, obs_vec, model_vec());
            end
        end
        in_valid = 1'b0; in_last = 1'b0;
        checks++;
        if (got.size() != 10) begin
            failures++;
            $display("FAIL basic_count got=%0d exp=10", got.size());
        end
        for (int i = 0; i < 10 && i < got.size(); i++) begin
            checks++;
            if (got[i] !== {i == 9, fib[i]}) begin
                failures++;
                $display("FAIL basic_term%0d got=%h exp=%h", i, got[i], {i == 9, fib[i]});
            end
        end
        checks++;
        if (dones != 1) begin
            failures++;
            $display("FAIL basic_seq_done_pulses got=%0d exp=1", dones);
        end
        checks++;
        if ({term_count, seq_err, overflow} !== {16'd10, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL basic_final got=%h exp=%h", {term_count, seq_err, overflow},
                     {16'd10, 1'b0, 1'b0});
        end
    endtask

    task automatic test_overflow();
        logic [31:0] fib[10] = '{0, 1, 1, 2, 3, 5, 8, 13, 21, 34};
        logic [32:0] got[$];
        clr = 1'b1; tick(); clr = 1'b0;
        out_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1; in_data = fib[i]; in_last = (i == 9);
            tick();
            checks++;
            if (obs_vec !== model_vec()) begin
                failures++;
                $display("FAIL ovf_fill%0d got=%h exp=%h", i, obs_vec, model_vec());
            end
        end
        in_valid = 1'b0; in_last = 1'b0;
        checks++;
        if ({overflow, term_count, out_valid, out_data} !== {1'b1, 16'd10, 1'b1, 32'd0}) begin
            failures++;
            $display("FAIL ovf_state got=%h exp=%h", {overflow, term_count, out_valid, out_data},
                     {1'b1, 16'd10, 1'b1, 32'd0});
        end
        out_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            if (out_valid && out_ready) got.push_back({out_last, out_data});
            tick();
            checks++;
            if (obs_vec !== model_vec()) begin
                failures++;
                $display("FAIL ovf_drain%0d got=%h exp=%h", i, obs_vec, model_vec());
            end
        end
        checks++;
        if (got.size() != 8) begin
            failures++;
            $display("FAIL ovf_drain_count got=%0d exp=8", got.size());
        end
        for (int i = 0; i < 8 && i < got.size(); i++) begin
            checks++;
            if (got[i] !== {1'b0, fib[i]}) begin
                failures++;
                $display("FAIL ovf_term%0d got=%h exp=%h", i, got[i], {1'b0, fib[i]});
            end
        end
        clr = 1'b1; tick(); clr = 1'b0;
        checks++;
        if (obs_vec !== 69'd0) begin
            failures++;
            $display("FAIL ovf_clr got=%h exp=0", obs_vec);
        end
    endtask

    task automatic test_seq_err();
        logic [31:0] s[6] = '{0, 1, 1, 2, 4, 6};
        int delivered = 0;
        clr = 1'b1; tick(); clr = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            in_valid = (i < 6);
            in_data  = (i < 6) ? s[i] : 32'd0;
            in_last  = (i == 5);
            if (out_valid && out_ready) delivered++;
            tick();
            checks++;
            if (obs_vec !== model_vec()) begin
                failures++;
                $display("FAIL err_cycle%0d got=%h exp=%h", i, obs_vec, model_vec());
            end
            if (i == 4 || i == 5) begin
                checks++;
                if ({seq_err, err_index} !== {CHECK_EN, CHECK_EN ? 16'd4 : 16'd0}) begin
                    failures++;
                    $display("FAIL err_after_term%0d got=%h exp=%h", i, {seq_err, err_index},
                             {CHECK_EN, CHECK_EN ? 16'd4 : 16'd0});
                end
            end
        end
        in_valid = 1'b0; in_last = 1'b0;
        checks++;
        if (delivered != 6) begin
            failures++;
            $display("FAIL err_delivered got=%0d exp=6", delivered);
        end
    endtask

    task automatic test_wrap8();
        logic [7:0] seq8[15];
        logic [8:0] got8[$];
        seq8[0] = 8'd0;
        seq8[1] = 8'd1;
        for (int i = 2; i < 15; i++) seq8[i] = seq8[i-1] + seq8[i-2];
        clr = 1'b1; tick(); clr = 1'b0;
        for (int i = 0; i < 30; i++) begin
            v8 = (i < 15);
            d8 = (i < 15) ? seq8[i] : 8'd0;
            l8 = (i == 14);
            if (out_valid8 && r8) got8.push_back({out_last8, out_data8});
            tick();
        end
        v8 = 1'b0; l8 = 1'b0;
        checks++;
        if (got8.size() != 15) begin
            failures++;
            $display("FAIL wrap8_count got=%0d exp=15", got8.size());
        end
        for (int i = 0; i < 15 && i < got8.size(); i++) begin
            checks++;
            if (got8[i] !== {i == 14, seq8[i]}) begin
                failures++;
                $display("FAIL wrap8_term%0d got=%h exp=%h", i, got8[i], {i == 14, seq8[i]});
            end
        end
        checks++;
        if ({seq_err8, term_count8, overflow8} !== {1'b0, 16'd15, 1'b0}) begin
            failures++;
            $display("FAIL wrap8_flags got=%h exp=%h", {seq_err8, term_count8, overflow8},
                     {1'b0, 16'd15, 1'b0});
        end
    endtask

    task automatic test_async_reset();
        logic [31:0] s[4] = '{0, 1, 1, 2};
        clr = 1'b1; tick(); clr = 1'b0;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_data = s[i]; in_last = 1'b0;
            tick();
        end
        in_valid = 1'b0;
        checks++;
        if ({out_valid, term_count} !== {1'b1, 16'd3}) begin
            failures++;
            $display("FAIL arst_before got=%h exp=%h", {out_valid, term_count}, {1'b1, 16'd3});
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (obs_vec !== 69'd0) begin
            failures++;
            $display("FAIL arst_immediate got=%h exp=0", obs_vec);
        end
        model_reset();
        @(posedge clk);
        #1 rst_n = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            in_valid = (i < 4);
            in_data  = (i < 4) ? s[i] : 32'd0;
            in_last  = (i == 3);
            tick();
            checks++;
            if (obs_vec !== model_vec()) begin
                failures++;
                $display("FAIL arst_restart%0d got=%h exp=%h", i, obs_vec, model_vec());
            end
        end
        in_valid = 1'b0; in_last = 1'b0;
        checks++;
        if ({seq_err, term_count} !== {1'b0, 16'd4}) begin
            failures++;
            $display("FAIL arst_restart_final got=%h exp=%h", {seq_err, term_count},
                     {1'b0, 16'd4});
        end
    endtask

    task automatic test_random();
        for (int s = 0; s < 5; s++) begin
            int len;
            int sent = 0;
            bit seen_done = 1'b0;
            logic [31:0] a = 32'd0;
            logic [31:0] b = 32'd1;
            logic [31:0] t;
            clr = 1'b1; tick(); clr = 1'b0;
            len = $urandom_range(6, 24);
            for (int c = 0; c < 400 && sent < len; c++) begin
                in_valid  = ($urandom_range(0, 3) != 0);
                out_ready = ($urandom_range(0, 2) != 0);
                t = (sent == 0) ? 32'd0 : (sent == 1) ? 32'd1 : a + b;
                in_data = ($urandom_range(0, 7) == 0) ? t ^ (32'd1 << $urandom_range(0, 31)) : t;
                in_last = (sent == len - 1);
                tick();
                checks++;
                if (obs_vec !== model_vec()) begin
                    failures++;
                    $display("FAIL rand%0d_run%0d got=%h exp=%h", s, c, obs_vec, model_vec());
                end
                if (in_valid) begin
                    if (sent >= 2) begin a = b; b = t; end
                    else if (sent == 1) begin a = 32'd0; b = 32'd1; end
                    sent++;
                end
            end
            in_valid = 1'b0; in_last = 1'b0;
            for (int c = 0; c < 200 && !seen_done; c++) begin
                out_ready = ($urandom_range(0, 2) != 0);
                tick();
                if (seq_done) seen_done = 1'b1;
                checks++;
                if (obs_vec !== model_vec()) begin
                    failures++;
                    $display("FAIL rand%0d_drain%0d got=%h exp=%h", s, c, obs_vec, model_vec());
                end
            end
            checks++;
            if (!seen_done) begin
                failures++;
                $display("FAIL rand%0d_done_timeout got=0 exp=1", s);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overflow();
        test_seq_err();
        test_wrap8();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        failures++;
        $display("FAIL watchdog got=timeout exp=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

endmodule
